// File: rtl/dmem_arbiter_pkg.sv
// Shared types and lane-formatting helpers for the data-memory arbiter.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic {
      ST_FAV_P0 = 1'b0,
      ST_FAV_P1 = 1'b1
   } arb_st_t;

   // request as seen at the accept stage
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        port;
   } req_t;

   // what the issue/response stages need to remember about an access
   typedef struct packed {
      logic       port;
      logic       err;
      logic       we;
      logic [1:0] size;
      logic       uns;
      logic [1:0] alo;
   } rsp_t;

   function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] alo);
      case (size)
         SZ_B:    return 4'b0001 << alo;
         SZ_H:    return alo[1] ? 4'b1100 : 4'b0011;
         SZ_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // shift the addressed byte/half down to bit 0, then extend
   function automatic logic [31:0] ld_fmt(input logic [31:0] rdata, input logic [1:0] size,
                                          input logic uns, input logic [1:0] alo);
      logic [31:0] sh;
      sh = rdata >> {alo, 3'b000};
      case (size)
         SZ_B:    return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         SZ_H:    return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: return rdata;
      endcase
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle and memory-side bus bundle.
interface dmem_arbiter_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, we, size, uns, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, size, uns, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

interface dmem_mem_if #(parameter int AW = 10);
   logic          en;
   logic          we;
   logic [3:0]    be;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic [31:0]   rdata;

   modport master (output en, we, be, addr, wdata, input rdata);
   modport slave  (input en, we, be, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_arbiter_lane_fmt.sv
// Combinational lane handling: byte enables, store replication, load extraction.
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_uns,
   input  logic [1:0]  i_alo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   assign o_be    = be_gen(i_size, i_alo);
   assign o_rdata = ld_fmt(i_rdata, i_size, i_uns, i_alo);

   // copy right-aligned store data onto every lane it could target
   always_comb begin
      o_wdata = i_wdata;
      case (i_size)
         SZ_B:    o_wdata = {4{i_wdata[7:0]}};
         SZ_H:    o_wdata = {2{i_wdata[15:0]}};
         default: o_wdata = i_wdata;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word memory.
// Accept (N) -> issue on mem_* (N+1) -> respond on rvalid/rdata (N+2).
//
// state     | meaning
// ST_FAV_P0 | on contention p0 wins (reset, or p1 was granted last)
// ST_FAV_P1 | on contention p1 wins (p0 was granted last)
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input logic            clk,
   input logic            rst,
   dmem_arbiter_if.slave  p0,
   dmem_arbiter_if.slave  p1,
   dmem_mem_if.master     mem
);

   arb_st_t       r_state;
   logic          w_gnt0, w_gnt1, w_any, w_err, w_go;
   req_t          w_sel;
   logic [3:0]    w_be;
   logic [31:0]   w_wrep, w_iss_ld_unused;

   logic          r_iss_vld, r_rsp_vld;
   rsp_t          r_iss, r_rsp;
   logic          r_mem_en, r_mem_we;
   logic [3:0]    r_mem_be;
   logic [AW-1:0] r_mem_addr;
   logic [31:0]   r_mem_wdata;
   logic [31:0]   r_hold0, r_hold1;

   logic [31:0]   w_ld_fmt, w_rsp_data;
   logic [3:0]    w_rsp_be_unused;
   logic [31:0]   w_rsp_wr_unused;

   // grant from req and pointer only; mem_rdata never reaches this path
   assign w_gnt0 = ~rst & p0.req & (~p1.req | (r_state == ST_FAV_P0));
   assign w_gnt1 = ~rst & p1.req & (~p0.req | (r_state == ST_FAV_P1));
   assign w_any  = w_gnt0 | w_gnt1;
   assign p0.gnt = w_gnt0;
   assign p1.gnt = w_gnt1;

   // mux the granted requester's fields
   always_comb begin
      w_sel = '0;
      if (w_gnt1) begin
         w_sel.we = p1.we;  w_sel.size = p1.size; w_sel.uns = p1.uns;
         w_sel.addr = p1.addr; w_sel.wdata = p1.wdata; w_sel.port = 1'b1;
      end else begin
         w_sel.we = p0.we;  w_sel.size = p0.size; w_sel.uns = p0.uns;
         w_sel.addr = p0.addr; w_sel.wdata = p0.wdata; w_sel.port = 1'b0;
      end
   end

   assign w_err = (w_sel.size == 2'd3)
                | ((w_sel.size == SZ_H) & w_sel.addr[0])
                | ((w_sel.size == SZ_W) & (w_sel.addr[1:0] != 2'b00))
                | (w_sel.addr[31:2] >= 30'(DEPTH));
   assign w_go  = w_any & ~w_err;

   dmem_lane_fmt u_iss_fmt (
      .i_size  (w_sel.size),
      .i_uns   (w_sel.uns),
      .i_alo   (w_sel.addr[1:0]),
      .i_wdata (w_sel.wdata),
      .i_rdata (32'd0),
      .o_be    (w_be),
      .o_wdata (w_wrep),
      .o_rdata (w_iss_ld_unused)
   );

   // round-robin pointer: moves away from whichever port was just granted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_FAV_P0;
      end else if (w_gnt0) begin
         r_state <= ST_FAV_P1;
      end else if (w_gnt1) begin
         r_state <= ST_FAV_P0;
      end
   end

   // issue and response pipeline; errored requests flow through without touching memory
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_iss_vld   <= 1'b0;
         r_iss       <= '0;
         r_rsp_vld   <= 1'b0;
         r_rsp       <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_hold0     <= '0;
         r_hold1     <= '0;
      end else begin
         r_iss_vld   <= w_any;
         r_iss       <= '{port: w_sel.port, err: w_err, we: w_sel.we, size: w_sel.size,
                          uns: w_sel.uns, alo: w_sel.addr[1:0]};
         r_mem_en    <= w_go;
         r_mem_we    <= w_go & w_sel.we;
         r_mem_be    <= w_go ? w_be : 4'b0000;
         r_mem_addr  <= w_go ? w_sel.addr[AW+1:2] : '0;
         r_mem_wdata <= (w_go & w_sel.we) ? w_wrep : 32'd0;
         r_rsp_vld   <= r_iss_vld;
         r_rsp       <= r_iss;
         if (r_rsp_vld & ~r_rsp.port) r_hold0 <= w_rsp_data;
         if (r_rsp_vld &  r_rsp.port) r_hold1 <= w_rsp_data;
      end
   end

   assign mem.en    = r_mem_en;
   assign mem.we    = r_mem_we;
   assign mem.be    = r_mem_be;
   assign mem.addr  = r_mem_addr;
   assign mem.wdata = r_mem_wdata;

   dmem_lane_fmt u_rsp_fmt (
      .i_size  (r_rsp.size),
      .i_uns   (r_rsp.uns),
      .i_alo   (r_rsp.alo),
      .i_wdata (32'd0),
      .i_rdata (mem.rdata),
      .o_be    (w_rsp_be_unused),
      .o_wdata (w_rsp_wr_unused),
      .o_rdata (w_ld_fmt)
   );

   // memory data arrives in N+2, so the response cycle passes it through and the hold keeps it
   assign w_rsp_data = (r_rsp.we | r_rsp.err) ? 32'd0 : w_ld_fmt;

   assign p0.rvalid = r_rsp_vld & ~r_rsp.port;
   assign p1.rvalid = r_rsp_vld &  r_rsp.port;
   assign p0.err    = r_rsp_vld & ~r_rsp.port & r_rsp.err;
   assign p1.err    = r_rsp_vld &  r_rsp.port & r_rsp.err;
   assign p0.rdata  = (r_rsp_vld & ~r_rsp.port) ? w_rsp_data : r_hold0;
   assign p1.rdata  = (r_rsp_vld &  r_rsp.port) ? w_rsp_data : r_hold1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a synchronous word-memory model.
module tb_dmem_arbiter;

   localparam int DEPTH = 1024;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   typedef struct {
      logic        port;
      int          cyc;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_rv = 0;
   logic fav1 = 1'b0;
   exp_t sb[$];
   logic [31:0] tb_mem  [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   cmd_t idle = '0;

   dmem_arbiter_if u_p0 ();
   dmem_arbiter_if u_p1 ();
   dmem_mem_if #(.AW(10)) u_mem ();

   dmem_arbiter #(.DEPTH(DEPTH), .AW(10)) dut (
      .clk (clk),
      .rst (rst),
      .p0  (u_p0),
      .p1  (u_p1),
      .mem (u_mem)
   );

   always #5 clk = ~clk;

   // synchronous single-port memory: data one cycle after en
   always @(posedge clk) begin
      cyc++;
      if (u_mem.en) begin
         if (u_mem.we)
            for (int i = 0; i < 4; i++)
               if (u_mem.be[i]) tb_mem[u_mem.addr][8*i +: 8] = u_mem.wdata[8*i +: 8];
         u_mem.rdata <= tb_mem[u_mem.addr];
      end
   end

   function automatic cmd_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr, logic [31:0] wdata);
      cmd_t c;
      c.we = we; c.size = size; c.uns = uns; c.addr = addr; c.wdata = wdata;
      return c;
   endfunction

   function automatic logic model_err(cmd_t c);
      return (c.size == 2'd3) || (c.size == 2'd1 && c.addr[0]) ||
             (c.size == 2'd2 && c.addr[1:0] != 2'b00) || (c.addr >= 32'(DEPTH * 4));
   endfunction

   function automatic logic [31:0] model_load(logic [31:0] w, cmd_t c);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*c.addr[1:0] +: 8];
      h = c.addr[1] ? w[31:16] : w[15:0];
      case (c.size)
         2'd0:    return c.uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'd1:    return c.uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return w;
      endcase
   endfunction

   task automatic push_exp(input logic port, input cmd_t c);
      exp_t e;
      e.port = port;
      e.cyc  = cyc + 2;
      e.err  = model_err(c);
      if (c.we && !e.err) begin
         case (c.size)
            2'd0:    ref_mem[c.addr[11:2]][8*c.addr[1:0] +: 8] = c.wdata[7:0];
            2'd1:    ref_mem[c.addr[11:2]][16*c.addr[1] +: 16] = c.wdata[15:0];
            default: ref_mem[c.addr[11:2]] = c.wdata;
         endcase
      end
      e.rdata = (c.we || e.err) ? 32'h0 : model_load(ref_mem[c.addr[11:2]], c);
      sb.push_back(e);
   endtask

   // one request cycle; grant checked against the bench's own round-robin model
   task automatic step(input logic r0, input cmd_t c0, input logic r1, input cmd_t c1,
                       output logic g0, output logic g1);
      logic eg0, eg1;
      @(negedge clk);
      u_p0.req = r0; u_p0.we = c0.we; u_p0.size = c0.size; u_p0.uns = c0.uns;
      u_p0.addr = c0.addr; u_p0.wdata = c0.wdata;
      u_p1.req = r1; u_p1.we = c1.we; u_p1.size = c1.size; u_p1.uns = c1.uns;
      u_p1.addr = c1.addr; u_p1.wdata = c1.wdata;
      #1;
      eg0 = r0 && (!r1 || !fav1);
      eg1 = r1 && (!r0 || fav1);
      g0 = u_p0.gnt;
      g1 = u_p1.gnt;
      n_checks++;
      if ({g0, g1} !== {eg0, eg1}) begin
         n_fail++;
         $display("FAIL gnt got p0=%b p1=%b want p0=%b p1=%b", g0, g1, eg0, eg1);
      end
      if (eg0) begin push_exp(1'b0, c0); fav1 = 1'b1; end
      else if (eg1) begin push_exp(1'b1, c1); fav1 = 1'b0; end
      @(posedge clk);
      #1;
      u_p0.req = 1'b0;
      u_p1.req = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending responses want 0", sb.size());
         sb.delete();
      end
      #1;
   endtask

   // response monitor: every rvalid must match the oldest expected entry
   always @(negedge clk) begin
      exp_t e;
      logic gp, ge;
      logic [31:0] gd;
      if (!rst) begin
         if (u_p0.rvalid || u_p1.rvalid) begin
            n_rv++;
            gp = u_p1.rvalid;
            ge = gp ? u_p1.err : u_p0.err;
            gd = gp ? u_p1.rdata : u_p0.rdata;
            n_checks++;
            if (u_p0.rvalid && u_p1.rvalid) begin
               n_fail++;
               $display("FAIL rvalid_both got p0=1 p1=1 want at most one at cycle %0d", cyc);
            end else if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_unexpected got rvalid port=%0d cycle=%0d want none", gp, cyc);
            end else begin
               e = sb.pop_front();
               if (gp !== e.port || cyc != e.cyc || ge !== e.err || gd !== e.rdata) begin
                  n_fail++;
                  $display("FAIL rsp got port=%0d cyc=%0d err=%b rdata=%h want port=%0d cyc=%0d err=%b rdata=%h",
                           gp, cyc, ge, gd, e.port, e.cyc, e.err, e.rdata);
               end
            end
         end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL rsp_missing got none want port=%0d at cycle %0d", e.port, e.cyc);
         end
      end
   end

   task automatic test_reset();
      u_p0.req = 0; u_p0.we = 0; u_p0.size = 0; u_p0.uns = 0; u_p0.addr = 0; u_p0.wdata = 0;
      u_p1.req = 0; u_p1.we = 0; u_p1.size = 0; u_p1.uns = 0; u_p1.addr = 0; u_p1.wdata = 0;
      for (int i = 0; i < DEPTH; i++) begin
         tb_mem[i]  = (i * 32'h01010101) ^ 32'hA5000000;
         ref_mem[i] = tb_mem[i];
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if ({u_p0.gnt, u_p0.rvalid, u_p0.err, u_p0.rdata, u_p1.gnt, u_p1.rvalid, u_p1.err, u_p1.rdata,
           u_mem.en, u_mem.we, u_mem.be, u_mem.addr, u_mem.wdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got p0.rdata=%h p1.rdata=%h mem.en=%b mem.be=%b want all zero",
                  u_p0.rdata, u_p1.rdata, u_mem.en, u_mem.be);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({u_p0.rvalid, u_p1.rvalid, u_mem.en} !== 3'b000) begin
         n_fail++;
         $display("FAIL idle_after_reset got rvalid=%b%b mem.en=%b want 000", u_p0.rvalid, u_p1.rvalid, u_mem.en);
      end
   endtask

   task automatic test_stores();
      logic g0, g1;
      logic [47:0] want [3];
      cmd_t c [3];
      c[0] = mk(1, 2'd0, 0, 32'd4,  32'd38);
      c[1] = mk(1, 2'd2, 0, 32'd8,  32'd54);
      c[2] = mk(1, 2'd1, 0, 32'd14, 32'd92);
      want[0] = {1'b1, 1'b1, 4'b0001, 10'd1, 32'h26262626};
      want[1] = {1'b1, 1'b1, 4'b1111, 10'd2, 32'd54};
      want[2] = {1'b1, 1'b1, 4'b1100, 10'd3, 32'h005C005C};
      for (int i = 0; i < 3; i++) begin
         step(1, c[i], 0, idle, g0, g1);
         n_checks++;
         if ({u_mem.en, u_mem.we, u_mem.be, u_mem.addr, u_mem.wdata} !== want[i]) begin
            n_fail++;
            $display("FAIL store%0d_issue got en=%b we=%b be=%b addr=%0d wdata=%h want %h",
                     i, u_mem.en, u_mem.we, u_mem.be, u_mem.addr, u_mem.wdata, want[i]);
         end
      end
      drain();
   endtask

   task automatic test_loads();
      logic g0, g1;
      tb_mem[3]  = 32'h0000FFF0;
      ref_mem[3] = 32'h0000FFF0;
      step(1, mk(0, 2'd1, 0, 32'd12, 0), 0, idle, g0, g1);
      n_checks++;
      if ({u_mem.en, u_mem.we, u_mem.be, u_mem.addr} !== {1'b1, 1'b0, 4'b0011, 10'd3}) begin
         n_fail++;
         $display("FAIL lh_issue got en=%b we=%b be=%b addr=%0d want en=1 we=0 be=0011 addr=3",
                  u_mem.en, u_mem.we, u_mem.be, u_mem.addr);
      end
      step(1, mk(0, 2'd1, 1, 32'd12, 0), 0, idle, g0, g1);
      step(1, mk(0, 2'd0, 0, 32'd13, 0), 0, idle, g0, g1);
      step(1, mk(0, 2'd0, 1, 32'd8, 0), 0, idle, g0, g1);
      drain();
      repeat (2) @(negedge clk);
      n_checks++;
      if (u_p0.rdata !== 32'h00000036) begin
         n_fail++;
         $display("FAIL rdata_hold got %h want 00000036", u_p0.rdata);
      end
   endtask

   task automatic test_contention();
      logic g0, g1;
      logic [3:0] seq;
      seq = '0;
      step(0, idle, 1, mk(0, 2'd2, 0, 32'd8, 0), g0, g1);
      for (int i = 0; i < 4; i++) begin
         step(1, mk(0, 2'd2, 0, 32'd12, 0), 1, mk(0, 2'd2, 0, 32'd8, 0), g0, g1);
         seq = {seq[2:0], g0};
      end
      n_checks++;
      if (seq !== 4'b1010) begin
         n_fail++;
         $display("FAIL contention_order got p0-grant pattern %b want 1010", seq);
      end
      drain();
   endtask

   task automatic test_errors();
      logic g0, g1;
      cmd_t c [4];
      c[0] = mk(0, 2'd2, 0, 32'd6,    0);
      c[1] = mk(0, 2'd2, 0, 32'd4096, 0);
      c[2] = mk(0, 2'd3, 0, 32'd0,    0);
      c[3] = mk(1, 2'd1, 0, 32'd1,    32'hFFFF);
      for (int i = 0; i < 4; i++) begin
         step(1, c[i], 0, idle, g0, g1);
         n_checks++;
         if (u_mem.en !== 1'b0) begin
            n_fail++;
            $display("FAIL err%0d_mem_en got %b want 0", i, u_mem.en);
         end
      end
      step(0, idle, 1, mk(0, 2'd2, 0, 32'd4092, 0), g0, g1);
      n_checks++;
      if ({u_mem.en, u_mem.addr} !== {1'b1, 10'd1023}) begin
         n_fail++;
         $display("FAIL last_word_issue got en=%b addr=%0d want en=1 addr=1023", u_mem.en, u_mem.addr);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic g0, g1;
      step(1, mk(1, 2'd2, 0, 32'd16, 32'hDEADBEEF), 0, idle, g0, g1);
      step(0, idle, 1, mk(0, 2'd2, 0, 32'd16, 0), g0, g1);
      step(1, mk(1, 2'd0, 0, 32'd17, 32'h11), 0, idle, g0, g1);
      step(1, mk(0, 2'd1, 1, 32'd16, 0), 0, idle, g0, g1);
      drain();
   endtask

   task automatic test_mid_reset();
      logic g0, g1;
      int rv_before;
      step(1, mk(0, 2'd2, 0, 32'd8, 0), 0, idle, g0, g1);
      rst = 1'b1;
      sb.delete();
      fav1 = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({u_p0.gnt, u_p0.rvalid, u_p0.err, u_p0.rdata, u_p1.gnt, u_p1.rvalid, u_p1.err, u_p1.rdata,
           u_mem.en, u_mem.we, u_mem.be, u_mem.addr, u_mem.wdata} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs got p0.rdata=%h mem.en=%b mem.be=%b want all zero",
                  u_p0.rdata, u_mem.en, u_mem.be);
      end
      rst = 1'b0;
      rv_before = n_rv;
      repeat (4) @(negedge clk);
      n_checks++;
      if (n_rv != rv_before) begin
         n_fail++;
         $display("FAIL midreset_stale_rvalid got %0d responses want 0", n_rv - rv_before);
      end
      step(1, mk(0, 2'd2, 0, 32'd0, 0), 1, mk(0, 2'd2, 0, 32'd4, 0), g0, g1);
      step(0, idle, 1, mk(0, 2'd2, 0, 32'd4, 0), g0, g1);
      drain();
   endtask

   initial begin
      test_reset();
      test_stores();
      test_loads();
      test_contention();
      test_errors();
      test_back_to_back();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
